// File: rtl/m3ds_tscnt_pkg.sv
// Shared constants, state encoding and index helper for the ETM timestamp counter controller.
package m3ds_tscnt_pkg;

  localparam int unsigned TS_W           = 48;
  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned PRESCALE_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_OFF    = 2'b00,
    ST_RUN    = 2'b01,
    ST_FROZEN = 2'b10
  } ts_state_e;

  // (base + off) mod n, used to walk the round-robin ring
  function automatic int unsigned rr_idx(input int unsigned base,
                                         input int unsigned off,
                                         input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/m3ds_tscnt_rr_arb.sv
// Combinational round-robin arbiter: one-hot grant among unmasked requests, search from ptr_i.
module m3ds_tscnt_rr_arb
  import m3ds_tscnt_pkg::*;
#(
  parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
  localparam int unsigned PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [NUM_REQ-1:0] mask_i,
  input  logic [PTR_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_c_o,
  output logic [PTR_W-1:0]   ptr_nxt_c_o
);

  logic [NUM_REQ-1:0] elig_c;
  logic               found_c;
  logic [PTR_W-1:0]   idx_c;

  assign elig_c = req_i & ~mask_i;

  // first eligible requester at or after the pointer wins; pointer moves just past it
  always_comb begin
    gnt_c_o     = '0;
    ptr_nxt_c_o = ptr_i;
    found_c     = 1'b0;
    idx_c       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx_c = PTR_W'(rr_idx(32'(ptr_i), k, NUM_REQ));
      if (!found_c && elig_c[idx_c]) begin
        found_c        = 1'b1;
        gnt_c_o[idx_c] = 1'b1;
        ptr_nxt_c_o    = PTR_W'(rr_idx(32'(idx_c), 32'd1, NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/m3ds_tscnt_ctrl.sv
// ETM timestamp counter controller: prescaled count enable with halt gating and snapshot arbitration.
// Halt freezing is built only when M3DS_TSCNT_HALT_FREEZE_EN is defined.
module m3ds_tscnt_ctrl
  import m3ds_tscnt_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ctrl_en_i,
  input  logic                  halted_i,
  input  logic [PRESCALE_W-1:0] prescale_i,
  input  logic [TS_W-1:0]       tsvalueb_i,
  output logic                  enablecnt_o,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    ack_o,
  output logic [TS_W-1:0]       snap_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ts_state_e             state_q, state_d;
  logic [PRESCALE_W-1:0] pscnt_q, pscnt_d;
  logic                  enablecnt_q, enablecnt_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;
  logic [TS_W-1:0]       snap_q, snap_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  halt_c;
  logic [NUM_REQ-1:0]    gnt_c;
  logic [PTR_W-1:0]      ptr_nxt_c;

`ifdef M3DS_TSCNT_HALT_FREEZE_EN
  assign halt_c = halted_i;
`else
  logic unused_halted;
  assign unused_halted = halted_i;
  assign halt_c        = 1'b0;
`endif

  // requesters acked this cycle are masked so a late req drop cannot double-grant
  m3ds_tscnt_rr_arb #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_i       (req_i),
    .mask_i      (ack_q),
    .ptr_i       (ptr_q),
    .gnt_c_o     (gnt_c),
    .ptr_nxt_c_o (ptr_nxt_c)
  );

  always_comb begin
    state_d     = state_q;
    pscnt_d     = pscnt_q;
    enablecnt_d = 1'b0;
    ack_d       = gnt_c;
    snap_d      = snap_q;
    ptr_d       = ptr_nxt_c;

    case (state_q)
      ST_OFF: begin
        if (ctrl_en_i) state_d = halt_c ? ST_FROZEN : ST_RUN;
      end
      ST_RUN: begin
        if (!ctrl_en_i)  state_d = ST_OFF;
        else if (halt_c) state_d = ST_FROZEN;
      end
      ST_FROZEN: begin
        if (!ctrl_en_i)   state_d = ST_OFF;
        else if (!halt_c) state_d = ST_RUN;
      end
      default: state_d = ST_OFF;
    endcase

    // prescaler clears on leaving to OFF, only advances while staying in RUN
    if (state_d == ST_OFF) begin
      pscnt_d = '0;
    end else if ((state_d == ST_RUN) && (state_q == ST_RUN)) begin
      pscnt_d = (pscnt_q == prescale_i) ? '0 : pscnt_q + PRESCALE_W'(1);
    end

    enablecnt_d = (state_d == ST_RUN) && (pscnt_d == prescale_i);

    if (|gnt_c) snap_d = tsvalueb_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_OFF;
      pscnt_q     <= '0;
      enablecnt_q <= 1'b0;
      ack_q       <= '0;
      snap_q      <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      pscnt_q     <= pscnt_d;
      enablecnt_q <= enablecnt_d;
      ack_q       <= ack_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
    end
  end

  assign enablecnt_o = enablecnt_q;
  assign ack_o       = ack_q;
  assign snap_o      = snap_q;

endmodule

// File: tb/tb_m3ds_tscnt_ctrl.sv
// Self-checking bench for m3ds_tscnt_ctrl with an attached counter model and a snapshot scoreboard.
module tb_m3ds_tscnt_ctrl;
  import m3ds_tscnt_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned IW = $clog2(N);
`ifdef M3DS_TSCNT_HALT_FREEZE_EN
  localparam bit HALT_FRZ = 1'b1;
`else
  localparam bit HALT_FRZ = 1'b0;
`endif

  typedef struct {
    logic [N-1:0]    ack;
    logic [TS_W-1:0] snap;
  } exp_t;

  logic            clk = 1'b0;
  logic            resetn;
  logic            ctrl_en;
  logic            halted;
  logic [PW-1:0]   prescale;
  logic [TS_W-1:0] ts;
  logic            enablecnt;
  logic [N-1:0]    req;
  logic [N-1:0]    ack;
  logic [TS_W-1:0] snap;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t            sb_q[$];
  logic [N-1:0]    m_ack;
  int unsigned     m_ptr;
  logic [TS_W-1:0] m_snap;

  always #5 clk = ~clk;

  m3ds_tscnt_ctrl #(
    .NUM_REQ    (N),
    .PRESCALE_W (PW)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .ctrl_en_i   (ctrl_en),
    .halted_i    (halted),
    .prescale_i  (prescale),
    .tsvalueb_i  (ts),
    .enablecnt_o (enablecnt),
    .req_i       (req),
    .ack_o       (ack),
    .snap_o      (snap)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ack  = '0;
    m_ptr  = 0;
    m_snap = '0;
    sb_q.delete();
  endtask

  // one clock: predict the grant for the inputs now applied, advance, then score the DUT
  task automatic cyc();
    exp_t         e;
    logic         en;
    logic [N-1:0] elig;
    int unsigned  nxt;
    en     = enablecnt;
    elig   = req & ~m_ack;
    e.ack  = '0;
    e.snap = m_snap;
    nxt    = m_ptr;
    for (int unsigned k = 0; k < N; k++) begin
      int unsigned i;
      i = (m_ptr + k) % N;
      if ((e.ack == '0) && elig[IW'(i)]) begin
        e.ack[IW'(i)] = 1'b1;
        e.snap        = ts;
        nxt           = (i + 1) % N;
      end
    end
    m_ptr  = nxt;
    m_ack  = e.ack;
    m_snap = e.snap;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (en) ts = ts + 48'd1;
    e = sb_q.pop_front();
    chk("ack", 64'(ack), 64'(e.ack));
    chk("snap", 64'(snap), 64'(e.snap));
  endtask

  initial begin
    logic [N-1:0] prev;
    int           order[$];

    resetn   = 1'b1;
    ctrl_en  = 1'b1;
    halted   = 1'b0;
    prescale = PW'(3);
    ts       = '0;
    req      = '0;
    model_reset();
    #1 resetn = 1'b0;
    #2;
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_snap", 64'(snap), 64'd0);
    chk("rst_en", 64'(enablecnt), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_OFF));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    // prescale 3: strobes on RUN cycles 4, 8, 12
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("t1_strobe", 64'(enablecnt), 64'((k % 4) == 0));
    end
    cyc();
    chk("t1_ts", 64'(ts), 64'd3);

    // prescale 0, then halt for 5 cycles
    ctrl_en = 1'b0;
    cyc();
    chk("t2_off", 64'(enablecnt), 64'd0);
    ctrl_en  = 1'b1;
    prescale = '0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("t2_run", 64'(enablecnt), 64'd1);
    end
    halted = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("t2_halt", 64'(enablecnt), HALT_FRZ ? 64'd0 : 64'd1);
    end
    halted = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("t2_resume", 64'(enablecnt), 64'd1);
    end

    // all four requesting, each drops req one cycle after its ack
    req  = '1;
    prev = '0;
    for (int k = 0; k < 7; k++) begin
      cyc();
      for (int i = 0; i < int'(N); i++) if (ack[IW'(i)]) order.push_back(i);
      req  = req & ~prev;
      prev = ack;
    end
    chk("t3_nacks", 64'(order.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("t3_order", 64'((i < order.size()) ? order[i] : 99), 64'(i));

    // disable with pscnt=2, prescale 5, then re-enable
    ctrl_en = 1'b0;
    cyc();
    ctrl_en  = 1'b1;
    prescale = PW'(5);
    repeat (3) cyc();
    chk("t5_pscnt_pre", 64'(dut.pscnt_q), 64'd2);
    ctrl_en = 1'b0;
    cyc();
    chk("t5_state_off", 64'(dut.state_q), 64'(ST_OFF));
    chk("t5_pscnt_clr", 64'(dut.pscnt_q), 64'd0);
    chk("t5_en_off", 64'(enablecnt), 64'd0);
    ctrl_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("t5_strobe", 64'(enablecnt), 64'(k == 6));
    end

    // counter at all-ones with a strobe pending and a snapshot requested
    ts  = 48'hFFFF_FFFF_FFFF;
    req = 4'b0100;
    cyc();
    chk("t4_wrap", 64'(ts), 64'd0);
    chk("t4_ack", 64'(ack), 64'b0100);
    chk("t4_snap", 64'(snap), 64'hFFFF_FFFF_FFFF);
    req = '0;
    cyc();

    // reset asserted during an ack
    ts  = 48'h1234;
    req = 4'b0100;
    cyc();
    chk("t6_ack_pre", 64'(ack), 64'b0100);
    chk("t6_snap_pre", 64'(snap), 64'h1234);
    resetn = 1'b0;
    #1;
    chk("t6_ack_rst", 64'(ack), 64'd0);
    chk("t6_snap_rst", 64'(snap), 64'd0);
    chk("t6_state_rst", 64'(dut.state_q), 64'(ST_OFF));
    chk("t6_en_rst", 64'(enablecnt), 64'd0);
    model_reset();
    req = '0;
    @(posedge clk);
    #1 resetn = 1'b1;

    // random request traffic with late deassert
    prescale = PW'(1);
    prev     = '0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      req  = req & ~prev;
      prev = ack;
      for (int i = 0; i < int'(N); i++)
        if (!req[IW'(i)] && !prev[IW'(i)] && ($urandom_range(0, 2) == 0)) req[IW'(i)] = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m3ds_tscnt_ctrl.md
Name: m3ds_tscnt_ctrl

Overview:
Controller for the 48-bit ETM timestamp counter.
- Sequences the counter's enable through a programmable prescaler and gates it on debug halt.
- Arbitrates snapshot requests from several requesters (ETM, trace sync, debug, SW mirror) and returns a coherent 48-bit captured value per grant.
- Sits between the system control logic and the timestamp counter, in the user partition.

Parameters:
- NUM_REQ, 4, number of snapshot requesters (2..8).
- PRESCALE_W, 8, width of the prescale divisor.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- ctrl_en_i  in  1  global timestamp enable (level).
- halted_i  in  1  core halted in debug (level).
- prescale_i  in  PRESCALE_W  divisor minus one; quasi-static.
- tsvalueb_i  in  48  current counter value.
- enablecnt_o  out  1  count-enable strobe to the counter.
- req_i  in  NUM_REQ  snapshot requests (level, held until ack).
- ack_o  out  NUM_REQ  one-hot, one-cycle snapshot acknowledge.
- snap_o  out  48  captured counter value; valid in the ack cycle, held until the next ack.

Behaviour:
Interface and reset:
- Single clock domain: clk with asynchronous active-low reset resetn.
- Reset values: state OFF, prescaler count 0, enablecnt_o 0, ack_o 0, snap_o 0, round-robin pointer 0.

State machine (registered; states OFF, RUN, FROZEN):
- OFF -> RUN when ctrl_en_i=1 and halted_i=0.
- OFF -> FROZEN when ctrl_en_i=1 and halted_i=1.
- RUN -> FROZEN when halted_i=1.
- FROZEN -> RUN when halted_i=0.
- Any state -> OFF when ctrl_en_i=0. This has priority over halt.

Prescaler (pscnt, PRESCALE_W bits):
- OFF: pscnt cleared to 0.
- FROZEN: pscnt holds its value.
- RUN: pscnt increments each cycle. When pscnt==prescale_i it wraps to 0.
- If prescale_i is reduced below pscnt, pscnt counts up, wraps at all-ones, then matches. No out-of-range compare shortcut.

enablecnt_o:
- enablecnt_o = (state==RUN) && (pscnt==prescale_i). Decoded from flops only; no input-to-output combinational path.
- prescale_i=0 in RUN gives enablecnt_o=1 every cycle.
- Halt or disable takes effect the cycle after halted_i/ctrl_en_i change. At most one extra strobe may occur.

Snapshot arbiter:
- req_i is sampled each cycle. One grant per cycle, round-robin.
- Search starts at the pointer. After granting index i, the pointer becomes (i+1) mod NUM_REQ.
- Grant registered: a req seen in cycle N gives ack_o[i]=1 and snap_o=tsvalueb_i (value sampled in cycle N), both in cycle N+1.
- Any requester acked in cycle N+1 is masked from arbitration in cycle N+1. This tolerates a one-cycle-late req deassert without a double grant.
- Snapshots are taken in every state, including OFF and FROZEN. The value is then static.
- Simultaneous snapshot grant and enablecnt_o strobe: the capture is the pre-increment value.
- All req_i low: ack_o=0, snap_o holds.
- Reset mid-handshake: ack_o is dropped immediately. Requesters must re-request.

Optional Feature:
Macro: M3DS_TSCNT_HALT_FREEZE_EN.
- Defined: halted_i drives FROZEN as described above.
- Undefined: halted_i is ignored and FROZEN is unreachable. The port is still present and its value is unused. The timestamp keeps counting in debug halt.

Decomposition:
- Package m3ds_tscnt_pkg contains:
  - TS_W=48 constant.
  - State encoding constants: OFF=2'b00, RUN=2'b01, FROZEN=2'b10.
  - Default NUM_REQ/PRESCALE_W constants.
- Sub-module m3ds_tscnt_rr_arb: parameterised NUM_REQ round-robin arbiter. Inputs are req and mask; outputs are one-hot grant and pointer update.
- Prescaler, FSM and snapshot register stay in the top module.

Test Plan:
1. Reset released, ctrl_en_i=1, halted_i=0, prescale_i=3 -> enablecnt_o pulses at cycles 4, 8, 12 after RUN entry; with the counter attached, tsvalueb reads 3 after 12 cycles.
2. prescale_i=0, RUN for 10 cycles, then halted_i=1 for 5 cycles, then 0 -> exactly 10 or 11 strobes before the freeze, none while frozen, resumes the cycle after release. With the macro undefined, strobes continue throughout.
3. req_i=4'b1111 held, acks deasserted one cycle late -> ack order 0,1,2,3, no double grant, each snap_o equals the tsvalueb_i sampled the prior cycle.
4. Counter preloaded to 48'hFFFF_FFFF_FFFF (force), one strobe -> wrap to 0. A snapshot requested in the strobe cycle returns 48'hFFFF_FFFF_FFFF.
5. ctrl_en_i dropped mid-count with pscnt=2, prescale_i=5 -> OFF next cycle, pscnt=0. Re-enable gives the first strobe after 6 cycles.
6. resetn asserted while ack_o[2]=1 and snap_o=48'h1234 -> ack_o=0 and snap_o=0 asynchronously, state OFF.
